wb_stage: RTL and testbench
===========================

# wb_stage

Writeback stage that drives the register file's write port (write_enable / w_addr / w_data) from instructions retiring out of MEM. Accepts one instruction per cycle over a valid/ready handshake, waits for variable-latency data-memory load responses, aligns and sign-/zero-extends load data, and issues exactly one single-cycle register write per retiring instruction. Sits between the MEM stage / data-memory response path and the regfile.

## Interface
Parameters:
- none; widths fixed (32-bit data, 5-bit register address).

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high
- in_valid  in  1  MEM presents an instruction
- in_ready  out  1  WB can accept; transfer when in_valid && in_ready
- in_rd  in  5  destination register
- in_reg_write  in  1  instruction writes rd
- in_is_load  in  1  result comes from data memory
- in_funct3  in  3  load width/sign (RV32I encoding)
- in_addr_lo  in  2  byte offset of load address
- in_alu_result  in  32  result for non-loads
- dmem_rvalid  in  1  load response valid (single-cycle pulse)
- dmem_rdata  in  32  raw aligned load word
- write_enable  out  1  regfile write strobe
- w_addr  out  5  regfile write address
- w_data  out  32  regfile write data
- retire_count  out  32  retired-instruction counter
- busy  out  1  state != IDLE

## Operation
- States: IDLE (nothing held), COMMIT (non-load held, writes this cycle), WAIT_LOAD (load held, awaiting dmem_rvalid), LCOMMIT (load data registered, writes this cycle).
- in_ready = 1 in IDLE, COMMIT, LCOMMIT; 0 in WAIT_LOAD.
- Accept non-load -> COMMIT; accept load -> WAIT_LOAD; no accept -> IDLE.
- WAIT_LOAD: dmem_rvalid=1 -> extract, register into w_data -> LCOMMIT; otherwise stay.
- dmem_rvalid outside WAIT_LOAD is ignored.
- write_enable = 1 in COMMIT/LCOMMIT only when held reg_write=1 and rd != 0; rd=0 or reg_write=0 still retires with no write.
- Loads with rd=0 still wait for dmem_rvalid.
- Load extraction (funct3): 000 LB byte[addr_lo] sign-ext; 001 LH half[addr_lo[1]] sign-ext; 010 LW word; 100 LBU zero-ext; 101 LHU zero-ext; 011/110/111 -> raw word. addr_lo[0] ignored for halfwords.
- retire_count += 1 in every COMMIT/LCOMMIT cycle; wraps 0xFFFFFFFF -> 0.
- w_addr/w_data hold last values when write_enable=0.

## Timing
- Reset: state IDLE, write_enable=0, w_addr=0, w_data=0, retire_count=0, busy=0, in_ready=1 (combinational from IDLE).
- Non-load: accepted cycle N -> write_enable high cycle N+1 only. Back-to-back non-loads give one write per cycle.
- Load: accepted N, rvalid at cycle M>=N+1 -> write M+1; in_ready low N+1..M, high from M+1.
- Accept in COMMIT/LCOMMIT overlaps with the write of the held instruction.
- Reset asserted mid-WAIT_LOAD: pending load dropped, no write, counter cleared; later stray rvalid ignored.

## Configuration
- WB_FWD_EN defined: extra outputs fwd_valid (1), fwd_rd (5), fwd_data (32), mirroring write_enable/w_addr/w_data the same cycle, plus load_pending (1, =WAIT_LOAD) and pending_rd (5, held rd, 0 when not pending) for the hazard unit. All reset to 0.
- Undefined: these ports and their logic are absent; core behaviour identical.

## Structure
- Package rv_wb_pkg: funct3 load constants (F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU), state encoding wb_state_t, XLEN=32, REG_AW=5.
- Sub-module load_extract: combinational (funct3, addr_lo, rdata) -> extended word; instantiated once.

## Test plan
- Reset then addi-like: in_rd=5, reg_write=1, alu=0x0000002A at cycle 1 -> cycle 2 write_enable=1, w_addr=5, w_data=0x2A, retire_count=1.
- 4 consecutive non-loads rd=1..4 -> writes on 4 consecutive cycles, in_ready constantly 1, retire_count=4.
- LB funct3=000, addr_lo=3, rvalid 3 cycles later with rdata=0x80FF_0000 -> w_data=0xFFFFFF80 one cycle after rvalid; in_ready low during wait.
- LHU addr_lo=2 rdata=0xBEEF_1234 -> 0x0000BEEF; LH same -> 0xFFFFBEEF; LW -> 0xBEEF1234.
- rd=0 with reg_write=1 -> no write_enable, retire_count increments; stray rvalid in IDLE -> no effect.
- Reset during WAIT_LOAD then rvalid -> no write, retire_count=0, state IDLE, in_ready=1.

Source files
------------

// File: rtl/rv_wb_pkg.sv
// Shared types and constants for the writeback stage: data widths,
// RV32I load funct3 encodings and the writeback FSM state encoding.
package rv_wb_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned REG_AW = 5;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_COMMIT    = 2'd1,
        S_WAIT_LOAD = 2'd2,
        S_LCOMMIT   = 2'd3
    } wb_state_t;

endpackage

// File: rtl/wb_stage_load_extract.sv
// Load data extraction: selects byte/halfword from an aligned memory word
// by address offset and sign- or zero-extends according to funct3.
module load_extract
    import rv_wb_pkg::*;
(
    input  logic [2:0]      i_funct3,
    input  logic [1:0]      i_addr_lo,
    input  logic [XLEN-1:0] i_rdata,
    output logic [XLEN-1:0] o_data_c
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = i_rdata[7:0];
        case (i_addr_lo)
            2'd1:    w_byte = i_rdata[15:8];
            2'd2:    w_byte = i_rdata[23:16];
            2'd3:    w_byte = i_rdata[31:24];
            default: w_byte = i_rdata[7:0];
        endcase
        // halfword selection ignores addr_lo[0]
        w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
    end

    always_comb begin
        o_data_c = i_rdata;
        case (i_funct3)
            F3_LB:   o_data_c = {{24{w_byte[7]}}, w_byte};
            F3_LH:   o_data_c = {{16{w_half[15]}}, w_half};
            F3_LW:   o_data_c = i_rdata;
            F3_LBU:  o_data_c = {24'd0, w_byte};
            F3_LHU:  o_data_c = {16'd0, w_half};
            default: o_data_c = i_rdata;
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: retires one instruction per cycle into the regfile write
// port, waiting on data-memory responses for loads. WB_FWD_EN adds forwarding/hazard outputs.
module wb_stage
    import rv_wb_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [REG_AW-1:0] in_rd,
    input  logic              in_reg_write,
    input  logic              in_is_load,
    input  logic [2:0]        in_funct3,
    input  logic [1:0]        in_addr_lo,
    input  logic [XLEN-1:0]   in_alu_result,
    input  logic              dmem_rvalid,
    input  logic [XLEN-1:0]   dmem_rdata,
    output logic              write_enable,
    output logic [REG_AW-1:0] w_addr,
    output logic [XLEN-1:0]   w_data,
    output logic [XLEN-1:0]   retire_count,
`ifdef WB_FWD_EN
    output logic              fwd_valid,
    output logic [REG_AW-1:0] fwd_rd,
    output logic [XLEN-1:0]   fwd_data,
    output logic              load_pending,
    output logic [REG_AW-1:0] pending_rd,
`endif
    output logic              busy
);

    wb_state_t         r_state;
    wb_state_t         w_next_state;

    logic [REG_AW-1:0] r_rd;
    logic              r_reg_write;
    logic [2:0]        r_funct3;
    logic [1:0]        r_addr_lo;

    logic              r_we;
    logic [REG_AW-1:0] r_w_addr;
    logic [XLEN-1:0]   r_w_data;
    logic [XLEN-1:0]   r_retire_count;

    logic              w_hold_en;
    logic              w_we_next;
    logic [REG_AW-1:0] w_addr_next;
    logic [XLEN-1:0]   w_data_next;
    logic              w_retire;
    logic [XLEN-1:0]   w_ext_data;

    load_extract u_load_extract (
        .i_funct3  (r_funct3),
        .i_addr_lo (r_addr_lo),
        .i_rdata   (dmem_rdata),
        .o_data_c  (w_ext_data)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state plus next values of the registered write port.
    always_comb begin
        w_next_state = r_state;
        w_hold_en    = 1'b0;
        w_we_next    = 1'b0;
        w_addr_next  = r_w_addr;
        w_data_next  = r_w_data;
        case (r_state)
            S_WAIT_LOAD: begin
                if (dmem_rvalid) begin
                    w_next_state = S_LCOMMIT;
                    if (r_reg_write && (r_rd != '0)) begin
                        w_we_next   = 1'b1;
                        w_addr_next = r_rd;
                        w_data_next = w_ext_data;
                    end
                end
            end
            default: begin
                if (in_valid) begin
                    w_hold_en = 1'b1;
                    if (in_is_load) begin
                        w_next_state = S_WAIT_LOAD;
                    end else begin
                        w_next_state = S_COMMIT;
                        if (in_reg_write && (in_rd != '0)) begin
                            w_we_next   = 1'b1;
                            w_addr_next = in_rd;
                            w_data_next = in_alu_result;
                        end
                    end
                end else begin
                    w_next_state = S_IDLE;
                end
            end
        endcase
    end

    assign w_retire = (w_next_state == S_COMMIT) || (w_next_state == S_LCOMMIT);

    // Held instruction fields, needed while a load is outstanding.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd        <= '0;
            r_reg_write <= 1'b0;
            r_funct3    <= '0;
            r_addr_lo   <= '0;
        end else if (w_hold_en) begin
            r_rd        <= in_rd;
            r_reg_write <= in_reg_write;
            r_funct3    <= in_funct3;
            r_addr_lo   <= in_addr_lo;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_we           <= 1'b0;
            r_w_addr       <= '0;
            r_w_data       <= '0;
            r_retire_count <= '0;
        end else begin
            r_we     <= w_we_next;
            r_w_addr <= w_addr_next;
            r_w_data <= w_data_next;
            if (w_retire) begin
                r_retire_count <= r_retire_count + XLEN'(1);
            end
        end
    end

    assign in_ready     = (r_state != S_WAIT_LOAD);
    assign busy         = (r_state != S_IDLE);
    assign write_enable = r_we;
    assign w_addr       = r_w_addr;
    assign w_data       = r_w_data;
    assign retire_count = r_retire_count;

`ifdef WB_FWD_EN
    assign fwd_valid    = r_we;
    assign fwd_rd       = r_w_addr;
    assign fwd_data     = r_w_data;
    assign load_pending = (r_state == S_WAIT_LOAD);
    assign pending_rd   = (r_state == S_WAIT_LOAD) ? r_rd : '0;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed cases plus randomized traffic
// checked against a transaction-level reference model.
module tb_wb_stage;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_rd;
    logic        in_reg_write;
    logic        in_is_load;
    logic [2:0]  in_funct3;
    logic [1:0]  in_addr_lo;
    logic [31:0] in_alu_result;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic        write_enable;
    logic [4:0]  w_addr;
    logic [31:0] w_data;
    logic [31:0] retire_count;
    logic        busy;
`ifdef WB_FWD_EN
    logic        fwd_valid;
    logic [4:0]  fwd_rd;
    logic [31:0] fwd_data;
    logic        load_pending;
    logic [4:0]  pending_rd;
`endif

    wb_stage dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_rd         (in_rd),
        .in_reg_write  (in_reg_write),
        .in_is_load    (in_is_load),
        .in_funct3     (in_funct3),
        .in_addr_lo    (in_addr_lo),
        .in_alu_result (in_alu_result),
        .dmem_rvalid   (dmem_rvalid),
        .dmem_rdata    (dmem_rdata),
        .write_enable  (write_enable),
        .w_addr        (w_addr),
        .w_data        (w_data),
        .retire_count  (retire_count),
`ifdef WB_FWD_EN
        .fwd_valid     (fwd_valid),
        .fwd_rd        (fwd_rd),
        .fwd_data      (fwd_data),
        .load_pending  (load_pending),
        .pending_rd    (pending_rd),
`endif
        .busy          (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: outstanding load plus expected visible outputs.
    bit          m_wait;
    logic [4:0]  m_rd;
    bit          m_rw;
    logic [2:0]  m_f3;
    logic [1:0]  m_lo;
    bit          e_we;
    bit          e_busy;
    logic [4:0]  e_addr;
    logic [31:0] e_data;
    logic [31:0] e_count;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%08h expected=0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [1:0] lo, input logic [31:0] word);
        logic [31:0] b;
        logic [31:0] h;
        b = (word >> (8 * int'(lo))) & 32'h0000_00FF;
        h = (word >> (16 * int'(lo[1]))) & 32'h0000_FFFF;
        case (f3)
            3'b000:  return (b >= 32'd128)   ? b - 32'd256   : b;
            3'b001:  return (h >= 32'd32768) ? h - 32'd65536 : h;
            3'b100:  return b;
            3'b101:  return h;
            default: return word;
        endcase
    endfunction

    task automatic model_reset();
        m_wait  = 0;
        m_rd    = '0;
        m_rw    = 0;
        m_f3    = '0;
        m_lo    = '0;
        e_we    = 0;
        e_busy  = 0;
        e_addr  = '0;
        e_data  = '0;
        e_count = '0;
    endtask

    task automatic check_all(input string ctx);
        check_eq({ctx, ":in_ready"}, 32'(in_ready), 32'(!m_wait));
        check_eq({ctx, ":busy"}, 32'(busy), 32'(e_busy));
        check_eq({ctx, ":we"}, 32'(write_enable), 32'(e_we));
        check_eq({ctx, ":w_addr"}, 32'(w_addr), 32'(e_addr));
        check_eq({ctx, ":w_data"}, w_data, e_data);
        check_eq({ctx, ":count"}, retire_count, e_count);
    endtask

    // Called at a negedge: drive one cycle of inputs, predict, then check at next negedge.
    task automatic step(input string ctx, input bit v, input logic [4:0] rd, input bit rw, input bit ld,
                        input logic [2:0] f3, input logic [1:0] lo, input logic [31:0] alu,
                        input bit rv, input logic [31:0] rdata);
        in_valid      = v;
        in_rd         = rd;
        in_reg_write  = rw;
        in_is_load    = ld;
        in_funct3     = f3;
        in_addr_lo    = lo;
        in_alu_result = alu;
        dmem_rvalid   = rv;
        dmem_rdata    = rdata;
        e_we = 0;
        if (m_wait) begin
            e_busy = 1;
            if (rv) begin
                m_wait = 0;
                e_count = e_count + 1;
                if (m_rw && m_rd != 0) begin
                    e_we   = 1;
                    e_addr = m_rd;
                    e_data = ref_load(m_f3, m_lo, rdata);
                end
            end
        end else if (v) begin
            e_busy = 1;
            if (ld) begin
                m_wait = 1;
                m_rd   = rd;
                m_rw   = rw;
                m_f3   = f3;
                m_lo   = lo;
            end else begin
                e_count = e_count + 1;
                if (rw && rd != 0) begin
                    e_we   = 1;
                    e_addr = rd;
                    e_data = alu;
                end
            end
        end else begin
            e_busy = 0;
        end
        @(negedge clk);
        check_all(ctx);
    endtask

    task automatic idle(input string ctx, input bit rv, input logic [31:0] rdata);
        step(ctx, 0, 5'd0, 0, 0, 3'd0, 2'd0, 32'd0, rv, rdata);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        check_all("reset");
        reset = 1'b0;
    endtask

    initial begin
        in_valid = 0; in_rd = 0; in_reg_write = 0; in_is_load = 0; in_funct3 = 0;
        in_addr_lo = 0; in_alu_result = 0; dmem_rvalid = 0; dmem_rdata = 0;
        do_reset();

        // addi-like write
        step("addi", 1, 5'd5, 1, 0, 3'd0, 2'd0, 32'h0000_002A, 0, 32'd0);
        check_eq("addi_we", 32'(write_enable), 32'd1);
        check_eq("addi_addr", 32'(w_addr), 32'd5);
        check_eq("addi_data", w_data, 32'h0000_002A);
        check_eq("addi_count", retire_count, 32'd1);
        idle("gap", 0, 32'd0);

        // back-to-back non-loads
        for (int i = 1; i <= 4; i++) begin
            step("b2b", 1, 5'(i), 1, 0, 3'd0, 2'd0, 32'(100 + i), 0, 32'd0);
            check_eq("b2b_we", 32'(write_enable), 32'd1);
            check_eq("b2b_addr", 32'(w_addr), 32'(i));
            check_eq("b2b_ready", 32'(in_ready), 32'd1);
        end
        check_eq("b2b_count", retire_count, 32'd5);
        idle("gap", 0, 32'd0);

        // LB with 3-cycle response latency
        step("lb_acc", 1, 5'd7, 1, 1, 3'b000, 2'd3, 32'd0, 0, 32'd0);
        check_eq("lb_wait_ready", 32'(in_ready), 32'd0);
        idle("lb_w1", 0, 32'd0);
        check_eq("lb_wait_we", 32'(write_enable), 32'd0);
        idle("lb_w2", 0, 32'd0);
        idle("lb_rv", 1, 32'h80FF_0000);
        check_eq("lb_data", w_data, 32'hFFFF_FF80);
        check_eq("lb_we", 32'(write_enable), 32'd1);
        check_eq("lb_ready_after", 32'(in_ready), 32'd1);

        // halfword and word loads from the same memory word
        step("lhu_acc", 1, 5'd8, 1, 1, 3'b101, 2'd2, 32'd0, 0, 32'd0);
        idle("lhu_rv", 1, 32'hBEEF_1234);
        check_eq("lhu_data", w_data, 32'h0000_BEEF);
        step("lh_acc", 1, 5'd9, 1, 1, 3'b001, 2'd2, 32'd0, 0, 32'd0);
        idle("lh_rv", 1, 32'hBEEF_1234);
        check_eq("lh_data", w_data, 32'hFFFF_BEEF);
        step("lw_acc", 1, 5'd10, 1, 1, 3'b010, 2'd0, 32'd0, 0, 32'd0);
        idle("lw_rv", 1, 32'hBEEF_1234);
        check_eq("lw_data", w_data, 32'hBEEF_1234);

        // rd=0 retires without writing; stray rvalid in IDLE is ignored
        step("rd0", 1, 5'd0, 1, 0, 3'd0, 2'd0, 32'hDEAD_BEEF, 0, 32'd0);
        check_eq("rd0_we", 32'(write_enable), 32'd0);
        check_eq("rd0_count", retire_count, 32'd10);
        idle("idle", 0, 32'd0);
        idle("stray", 1, 32'h1234_5678);
        check_eq("stray_we", 32'(write_enable), 32'd0);
        check_eq("stray_count", retire_count, 32'd10);

        // load to rd=0 still waits for its response
        step("ld0_acc", 1, 5'd0, 1, 1, 3'b010, 2'd0, 32'd0, 0, 32'd0);
        check_eq("ld0_ready", 32'(in_ready), 32'd0);
        idle("ld0_rv", 1, 32'h5555_AAAA);
        check_eq("ld0_we", 32'(write_enable), 32'd0);

        // reset in the middle of a pending load
        step("rst_acc", 1, 5'd12, 1, 1, 3'b010, 2'd0, 32'd0, 0, 32'd0);
        idle("rst_w", 0, 32'd0);
        #2 reset = 1'b1;
        #1;
        model_reset();
        check_eq("rst_async_busy", 32'(busy), 32'd0);
        check_eq("rst_async_ready", 32'(in_ready), 32'd1);
        check_eq("rst_async_count", retire_count, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        idle("rst_stray", 1, 32'hFFFF_FFFF);
        check_eq("rst_stray_we", 32'(write_enable), 32'd0);
        check_eq("rst_stray_count", retire_count, 32'd0);

        // randomized traffic
        for (int c = 0; c < 600; c++) begin
            step("rnd", ($urandom_range(0, 9) < 7), 5'($urandom_range(0, 31)), 1'($urandom_range(0, 7) != 0),
                 1'($urandom_range(0, 9) < 4), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
                 $urandom, ($urandom_range(0, 9) < 3), $urandom);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
